// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access size
// encodings, latched request fields and alignment helpers.
package lsu_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned MASK_W = XLEN / 8;
    localparam int unsigned RD_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Request fields kept for the lifetime of one access
    typedef struct packed {
        logic       wen;
        logic [1:0] size;
        logic       uns;
        logic [2:0] off;
    } acc_t;

    function automatic logic [MASK_W-1:0] size_mask(input logic [1:0] size);
        logic [MASK_W-1:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = |off[1:0];
            default: bad = |off;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/data placement into the doubleword and
// load lane extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]        st_size,
    input  logic [2:0]        st_off,
    input  logic [XLEN-1:0]   st_wdata,
    output logic [MASK_W-1:0] st_mask_c,
    output logic [XLEN-1:0]   st_wdata_c,
    input  logic [1:0]        ld_size,
    input  logic [2:0]        ld_off,
    input  logic              ld_unsigned,
    input  logic [XLEN-1:0]   ld_rdata,
    output logic [XLEN-1:0]   ld_data_c
);

    logic [5:0]      st_sh;
    logic [5:0]      ld_sh;
    logic [XLEN-1:0] lane;

    always_comb begin
        st_sh      = {st_off, 3'b000};
        st_mask_c  = size_mask(st_size) << st_off;
        st_wdata_c = st_wdata << st_sh;
    end

    // Right-justify the addressed lane, then extend to the full width
    always_comb begin
        ld_sh = {ld_off, 3'b000};
        lane  = ld_rdata >> ld_sh;
        case (ld_size)
            SZ_B:    ld_data_c = ld_unsigned ? {56'b0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
            SZ_H:    ld_data_c = ld_unsigned ? {48'b0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            SZ_W:    ld_data_c = ld_unsigned ? {32'b0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            default: ld_data_c = lane;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit: accepts one access from execute, issues it
// to memory, formats the load result and reports completion or error.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [RD_W-1:0]   req_rd,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [RD_W-1:0]   resp_rd,
    output logic [XLEN-1:0]   resp_data
);

    // Counter may reach TIMEOUT_CYCLES when the handshake lands on the last REQ cycle
    localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_n;
    acc_t              acc;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              accept_c;
    logic              err_c;
    logic              load_done_c;
    logic [MASK_W-1:0] st_mask_c;
    logic [XLEN-1:0]   st_wdata_c;
    logic [XLEN-1:0]   ld_data_c;

    lsu_align u_align (
        .st_size     (req_size),
        .st_off      (req_addr[2:0]),
        .st_wdata    (req_wdata),
        .st_mask_c   (st_mask_c),
        .st_wdata_c  (st_wdata_c),
        .ld_size     (acc.size),
        .ld_off      (acc.off),
        .ld_unsigned (acc.uns),
        .ld_rdata    (mem_rdata),
        .ld_data_c   (ld_data_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // A completing handshake or read response wins over the timeout in the same cycle
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        accept_c    = 1'b0;
        err_c       = 1'b0;
        load_done_c = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept_c = 1'b1;
                    cnt_n    = '0;
                    if (misaligned(req_size, req_addr[2:0])) begin
                        state_n = RESP;
                        err_c   = 1'b1;
                    end else begin
                        state_n = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_valid && mem_ready) begin
                    state_n = acc.wen ? RESP : WAIT;
                    cnt_n   = cnt + CNT_W'(1);
                end else if (cnt >= CNT_LAST) begin
                    state_n = RESP;
                    err_c   = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_n     = RESP;
                    load_done_c = 1'b1;
                end else if (cnt >= CNT_LAST) begin
                    state_n = RESP;
                    err_c   = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs follow the next state so they line up with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready  <= 1'b1;
            mem_valid  <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rd    <= '0;
            resp_data  <= '0;
            acc        <= '0;
        end else begin
            req_ready  <= (state_n == IDLE);
            mem_valid  <= (state_n == REQ);
            resp_valid <= (state_n == RESP);
            resp_err   <= err_c;
            resp_data  <= load_done_c ? ld_data_c : '0;
            if (accept_c) begin
                acc.wen   <= req_wen;
                acc.size  <= req_size;
                acc.uns   <= req_unsigned;
                acc.off   <= req_addr[2:0];
                resp_rd   <= req_rd;
                mem_addr  <= {req_addr[XLEN-1:3], 3'b000};
                mem_wdata <= st_wdata_c;
            end
            if (state_n != REQ) begin
                mem_wen   <= 1'b0;
                mem_wmask <= '0;
            end else if (accept_c) begin
                mem_wen   <= req_wen;
                mem_wmask <= st_mask_c;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: table of single accesses plus hand sequences for stalls,
// timeout and mid-access reset; responses checked through a scoreboard queue.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_wen, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_ready, mem_rvalid;
    logic [63:0] mem_rdata;

    logic        req_ready, mem_valid, mem_wen, resp_valid, resp_err;
    logic [63:0] mem_addr, mem_wdata, resp_data;
    logic [7:0]  mem_wmask;
    logic [4:0]  resp_rd;

    logic        req_ready_t, mem_valid_t, mem_wen_t, resp_valid_t, resp_err_t;
    logic [63:0] mem_addr_t, mem_wdata_t, resp_data_t;
    logic [7:0]  mem_wmask_t;
    logic [4:0]  resp_rd_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [4:0]  rd;
        logic [63:0] rdata;
        logic        err;
        logic [63:0] data;
        logic [63:0] maddr;
        logic [7:0]  mask;
        logic [63:0] mwdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [4:0]  rd;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;
    vec_t tbl[16];
    vec_t v;

    lsu dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rd(resp_rd), .resp_data(resp_data)
    );

    lsu #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready_t), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_valid(mem_valid_t), .mem_ready(mem_ready), .mem_wen(mem_wen_t),
        .mem_addr(mem_addr_t), .mem_wdata(mem_wdata_t), .mem_wmask(mem_wmask_t),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid_t), .resp_err(resp_err_t), .resp_rd(resp_rd_t), .resp_data(resp_data_t)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: every completion pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_resp: got resp_valid rd=%0d expected none", resp_rd);
            end else begin
                got_e = sb.pop_front();
                chk("resp_err", 64'(resp_err), 64'(got_e.err));
                chk("resp_rd", 64'(resp_rd), 64'(got_e.rd));
                chk("resp_data", resp_data, got_e.data);
                chk("resp_latency", 64'(cyc), 64'(got_e.cyc));
            end
        end
    end

    function automatic vec_t mk(input logic wen, input logic [1:0] size, input logic uns,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [4:0] rd, input logic [63:0] rdata,
                                input logic err, input logic [63:0] data,
                                input logic [63:0] maddr, input logic [7:0] mask,
                                input logic [63:0] mwdata);
        vec_t r;
        r.wen = wen; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
        r.rd = rd; r.rdata = rdata; r.err = err; r.data = data; r.maddr = maddr;
        r.mask = mask; r.mwdata = mwdata;
        return r;
    endfunction

    task automatic drive_req(input vec_t x);
        req_valid    = 1'b1;
        req_wen      = x.wen;
        req_size     = x.size;
        req_unsigned = x.uns;
        req_addr     = x.addr;
        req_wdata    = x.wdata;
        req_rd       = x.rd;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL resp_wait: got %0d pending responses expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // One access: mem_ready withheld rdy_wait cycles, read data rv_wait cycles into WAIT
    task automatic run_access(input vec_t x, input int rdy_wait, input int rv_wait);
        exp_t e;
        @(negedge clk);
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        drive_req(x);
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        e.err  = x.err;
        e.rd   = x.rd;
        e.data = x.data;
        e.cyc  = cyc + (x.err ? 1 : (x.wen ? 2 + rdy_wait : 3 + rdy_wait + rv_wait));
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_busy", 64'(req_ready), 64'd0);
        if (x.err) begin
            chk("misaligned_no_mem_valid", 64'(mem_valid), 64'd0);
        end else begin
            for (int j = 0; j <= rdy_wait; j++) begin
                chk("mem_valid", 64'(mem_valid), 64'd1);
                chk("mem_addr", mem_addr, x.maddr);
                chk("mem_wmask", 64'(mem_wmask), 64'(x.mask));
                chk("mem_wen", 64'(mem_wen), 64'(x.wen));
                if (x.wen) chk("mem_wdata", mem_wdata, x.mwdata);
                mem_ready  = (j == rdy_wait);
                mem_rvalid = !x.wen;
                mem_rdata  = ~x.rdata;
                @(negedge clk);
            end
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            if (!x.wen) begin
                for (int j = 0; j <= rv_wait; j++) begin
                    mem_rvalid = (j == rv_wait);
                    mem_rdata  = (j == rv_wait) ? x.rdata : ~x.rdata;
                    @(negedge clk);
                end
                mem_rvalid = 1'b0;
            end
        end
        drain();
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid  = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Timeout instance: mem_ready never rises, so the access aborts after 4 REQ cycles
    task automatic timeout_seq(input logic [4:0] rd);
        vec_t x;
        x = mk(1'b0, SZ_W, 1'b0, 64'h9000, 64'h0, rd, 64'h0, 1'b1, 64'h0, 64'h9000, 8'h0F, 64'h0);
        chk("to_req_ready_idle", 64'(req_ready_t), 64'd1);
        drive_req(x);
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            chk("to_mem_valid", 64'(mem_valid_t), 64'd1);
            chk("to_no_resp_yet", 64'(resp_valid_t), 64'd0);
            @(negedge clk);
        end
        chk("to_resp_valid", 64'(resp_valid_t), 64'd1);
        chk("to_resp_err", 64'(resp_err_t), 64'd1);
        chk("to_resp_data", resp_data_t, 64'd0);
        chk("to_resp_rd", 64'(resp_rd_t), 64'(rd));
        chk("to_mem_valid_drop", 64'(mem_valid_t), 64'd0);
        @(negedge clk);
        chk("to_resp_one_cycle", 64'(resp_valid_t), 64'd0);
        chk("to_back_to_idle", 64'(req_ready_t), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = SZ_B; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        repeat (2) @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_mem_valid", 64'(mem_valid), 64'd0);
        chk("reset_mem_wen", 64'(mem_wen), 64'd0);
        chk("reset_mem_wmask", 64'(mem_wmask), 64'd0);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_resp_err", 64'(resp_err), 64'd0);
        chk("reset_resp_data", resp_data, 64'd0);
        rst_n = 1'b1;

        //          wen  size  uns  addr                  wdata                   rd     rdata                   err  data                    maddr          mask   mwdata
        tbl[0]  = mk(0, SZ_W, 0, 64'h8000_0004, 64'h0,               5'd5,  64'h8000_0000_1234_5678, 0, 64'hFFFF_FFFF_8000_0000, 64'h8000_0000, 8'hF0, 64'h0);
        tbl[1]  = mk(0, SZ_W, 1, 64'h8000_0004, 64'h0,               5'd6,  64'h8000_0000_1234_5678, 0, 64'h0000_0000_8000_0000, 64'h8000_0000, 8'hF0, 64'h0);
        tbl[2]  = mk(1, SZ_B, 0, 64'h8000_0003, 64'hAB,              5'd7,  64'h0,                   0, 64'h0,                   64'h8000_0000, 8'h08, 64'h0000_0000_AB00_0000);
        tbl[3]  = mk(0, SZ_H, 0, 64'h8000_0001, 64'h0,               5'd8,  64'h0,                   1, 64'h0,                   64'h0,         8'h00, 64'h0);
        tbl[4]  = mk(0, SZ_B, 0, 64'h1007,      64'h0,               5'd9,  64'h8000_0000_0000_0000, 0, 64'hFFFF_FFFF_FFFF_FF80, 64'h1000,      8'h80, 64'h0);
        tbl[5]  = mk(0, SZ_B, 1, 64'h1007,      64'h0,               5'd10, 64'h8000_0000_0000_0000, 0, 64'h80,                  64'h1000,      8'h80, 64'h0);
        tbl[6]  = mk(0, SZ_H, 0, 64'h2006,      64'h0,               5'd11, 64'hFFFE_1234_5678_9ABC, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h2000,      8'hC0, 64'h0);
        tbl[7]  = mk(0, SZ_D, 0, 64'h3000,      64'h0,               5'd12, 64'h0123_4567_89AB_CDEF, 0, 64'h0123_4567_89AB_CDEF, 64'h3000,      8'hFF, 64'h0);
        tbl[8]  = mk(1, SZ_W, 0, 64'h4004,      64'hDEAD_BEEF,       5'd13, 64'h0,                   0, 64'h0,                   64'h4000,      8'hF0, 64'hDEAD_BEEF_0000_0000);
        tbl[9]  = mk(1, SZ_D, 0, 64'h5008,      64'h1122_3344_5566_7788, 5'd14, 64'h0,               0, 64'h0,                   64'h5008,      8'hFF, 64'h1122_3344_5566_7788);
        tbl[10] = mk(1, SZ_W, 0, 64'h4002,      64'h55,              5'd15, 64'h0,                   1, 64'h0,                   64'h0,         8'h00, 64'h0);
        tbl[11] = mk(0, SZ_D, 0, 64'h3004,      64'h0,               5'd16, 64'h0,                   1, 64'h0,                   64'h0,         8'h00, 64'h0);
        tbl[12] = mk(1, SZ_H, 0, 64'h6002,      64'hBEEF,            5'd17, 64'h0,                   0, 64'h0,                   64'h6000,      8'h0C, 64'h0000_0000_BEEF_0000);
        tbl[13] = mk(0, SZ_W, 1, 64'h7000,      64'h0,               5'd18, 64'h1111_1111_FEDC_BA98, 0, 64'h0000_0000_FEDC_BA98, 64'h7000,      8'h0F, 64'h0);
        tbl[14] = mk(0, SZ_H, 0, 64'h2004,      64'h0,               5'd19, 64'h0000_7FFF_0000_0000, 0, 64'h7FFF,                64'h2000,      8'h30, 64'h0);
        tbl[15] = mk(0, SZ_B, 0, 64'h8000,      64'h0,               5'd20, 64'hFFFF_FFFF_FFFF_FF7F, 0, 64'h7F,                  64'h8000,      8'h01, 64'h0);

        foreach (tbl[i]) run_access(tbl[i], 0, 0);

        // Stalled doubleword load and stalled store
        v = tbl[7];  v.rd = 5'd21; run_access(v, 3, 2);
        v = tbl[8];  v.rd = 5'd22; run_access(v, 2, 0);

        // Reset during WAIT abandons the load; a late read response is ignored
        @(negedge clk);
        drive_req(tbl[0]);
        mem_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("wait_req_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_req_ready", 64'(req_ready), 64'd1);
        chk("async_rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("async_rst_mem_wen", 64'(mem_wen), 64'd0);
        chk("async_rst_mem_wmask", 64'(mem_wmask), 64'd0);
        chk("async_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("async_rst_resp_err", 64'(resp_err), 64'd0);
        chk("async_rst_resp_data", resp_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            mem_rvalid = (j < 2);
            mem_rdata  = tbl[0].rdata;
            @(negedge clk);
            chk("no_resp_after_reset", 64'(resp_valid), 64'd0);
        end
        mem_rvalid = 1'b0;
        v = tbl[0]; v.rd = 5'd25; run_access(v, 0, 0);

        do_reset();
        timeout_seq(5'd23);
        timeout_seq(5'd24);
        do_reset();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles spent in REQ+WAIT before the access is aborted.
REQ-002 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port req_valid  input  1  execute stage presents an access.
REQ-005 Port req_ready  output  1  LSU accepts an access this cycle.
REQ-006 Port req_wen  input  1  1 = store, 0 = load.
REQ-007 Port req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double.
REQ-008 Port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 Port req_addr  input  64  byte address, i.e. the ALU effective address src1+src2.
REQ-010 Port req_wdata  input  64  store data, right-aligned.
REQ-011 Port req_rd  input  5  destination register tag, returned unchanged.
REQ-012 Port mem_valid / mem_ready  output / input  1 / 1  memory request handshake.
REQ-013 Port mem_wen, mem_addr, mem_wdata, mem_wmask  output  1, 64, 64, 8  write enable, 8-byte-aligned address, lane-shifted data, byte mask.
REQ-014 Port mem_rvalid / mem_rdata  input  1 / 64  read response, aligned doubleword.
REQ-015 Port resp_valid, resp_err, resp_rd, resp_data  output  1, 1, 5, 64  completion pulse, error flag, tag, formatted load data (0 for stores).

Function
REQ-016 FSM states: IDLE, REQ, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 IDLE with req_valid=1: latch all req_* fields; go to RESP with resp_err=1 if misaligned (half: addr[0]!=0; word: addr[1:0]!=0; double: addr[2:0]!=0); otherwise go to REQ.
REQ-018 In REQ: mem_valid=1; mem_addr={addr[63:3],3'b0}; mem_wmask = size mask (1, 3, 0xF, 0xFF) shifted left by addr[2:0]; mem_wdata = wdata shifted left by 8*addr[2:0]; outputs held stable until mem_ready.
REQ-019 mem_valid&&mem_ready in REQ: store goes to RESP; load goes to WAIT.
REQ-020 mem_rvalid is honoured only in WAIT and is ignored in every other state; in WAIT, mem_rvalid=1 captures the lane starting at byte addr[2:0], extends it to 64 bits per size and req_unsigned, and goes to RESP.
REQ-021 RESP: resp_valid=1 for exactly one cycle, then IDLE; minimum latency from acceptance to resp_valid is 2 cycles for a store and 3 for a load (1 for a misaligned access).
REQ-022 A cycle counter clears on entry to REQ and counts in REQ and WAIT; on reaching TIMEOUT_CYCLES: go to RESP with resp_err=1, resp_data=0, mem_valid deasserted.
REQ-023 Only one access is in flight at a time; back-to-back accesses are separated by at least one IDLE cycle.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE; req_ready=1; mem_valid=0, mem_wen=0, mem_wmask=0; resp_valid=0, resp_err=0, resp_data=0; counter=0.
REQ-025 Reset asserted mid-access abandons that access: no resp_valid follows, and a late mem_rvalid is ignored.

Structure
REQ-026 Package lsu_pkg SHALL hold the state enum and the size encodings SZ_B/SZ_H/SZ_W/SZ_D.
REQ-027 Combinational sub-module lsu_align SHALL generate the store mask/data shift and the load extract/extend; lsu holds the FSM, latches and counter.

Verification
REQ-028 Load word, signed, addr 0x80000004, mem_rdata 0x80000000_12345678 -> resp_data 0xFFFFFFFF_80000000; the same access with unsigned -> 0x00000000_80000000.
REQ-029 Store byte, addr 0x80000003, wdata 0xAB -> mem_addr 0x80000000, mem_wmask 0x08, mem_wdata[31:24]=0xAB, resp_valid 2 cycles after acceptance with mem_ready held at 1.
REQ-030 Load half, addr 0x80000001 -> no mem_valid, resp_valid with resp_err=1 in the cycle after acceptance.
REQ-031 Load double with mem_ready held 0 for 3 cycles, then mem_rvalid 2 cycles later with 0x0123456789ABCDEF -> resp_data 0x0123456789ABCDEF and resp_rd echoed.
REQ-032 TIMEOUT_CYCLES=4, mem_ready stuck at 0 -> resp_err=1 after 4 cycles in REQ, then IDLE.
REQ-033 rst_n pulsed low during WAIT, then mem_rvalid asserted -> no resp_valid, and the next access completes correctly.
